// File: rtl/mptw_req_arbiter.sv
// Round-robin arbiter feeding a page-table walker, with in-order response routing via an ID FIFO.
// Optional per-requester grant counters are enabled by defining MPTW_ARB_PERF_EN.
module mptw_req_arbiter #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned RSP_WIDTH       = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic                          walk_valid_o,
  input  logic                          walk_ready_i,
  output logic [DATA_WIDTH-1:0]         walk_data_o,
  input  logic                          rsp_valid_i,
  output logic                          rsp_ready_o,
  input  logic [RSP_WIDTH-1:0]          rsp_data_i,
  output logic [NUM_REQ-1:0]            cli_rsp_valid_o,
  input  logic [NUM_REQ-1:0]            cli_rsp_ready_i,
  output logic [RSP_WIDTH-1:0]          cli_rsp_data_o,
  input  logic                          flush_i,
  output logic                          busy_o,
  output logic                          err_o
`ifdef MPTW_ARB_PERF_EN
  ,
  output logic [NUM_REQ*16-1:0]         grant_cnt_o
`endif
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned PtrW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [IdxW-1:0] idx_t;

  idx_t            rr_ptr_q, rr_ptr_d;
  logic            lock_q, lock_d;
  idx_t            lock_idx_q, lock_idx_d;
  idx_t            fifo_q [MAX_OUTSTANDING];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            err_q;

  logic fifo_full, fifo_empty;
  logic arb_found;
  idx_t arb_idx, cand, grant_idx, head_idx;
  logic walk_hs, rsp_pop, orphan;

  assign fifo_full  = (count_q == CntW'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);
  assign head_idx   = fifo_q[rd_ptr_q];

  // First valid requester searching upward from rr_ptr with wrap.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = rr_ptr_q;
    cand      = rr_ptr_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IdxW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!arb_found && req_valid_i[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // A stalled grant keeps its winner until the walker accepts it.
  assign grant_idx = lock_q ? lock_idx_q : arb_idx;

  always_comb begin
    walk_valid_o = !rst_i && !flush_i && !fifo_full && (lock_q || arb_found);
    walk_data_o  = req_data_i[32'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    req_ready_o  = '0;
    if (walk_valid_o) req_ready_o[grant_idx] = walk_ready_i;
  end

  assign walk_hs = walk_valid_o && walk_ready_i;

  always_comb begin
    cli_rsp_valid_o = '0;
    rsp_ready_o     = 1'b0;
    rsp_pop         = 1'b0;
    orphan          = 1'b0;
    if (!rst_i) begin
      if (flush_i) begin
        rsp_ready_o = 1'b1;
      end else if (fifo_empty) begin
        // Nobody is waiting: sink the beat and flag it.
        rsp_ready_o = 1'b1;
        orphan      = rsp_valid_i;
      end else begin
        cli_rsp_valid_o[head_idx] = rsp_valid_i;
        rsp_ready_o               = cli_rsp_ready_i[head_idx];
        rsp_pop                   = rsp_valid_i && cli_rsp_ready_i[head_idx];
      end
    end
  end

  assign cli_rsp_data_o = rsp_data_i;
  assign busy_o         = (count_q != '0);
  assign err_o          = err_q;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (flush_i) begin
      rr_ptr_d = '0;
      lock_d   = 1'b0;
    end else if (walk_hs) begin
      rr_ptr_d = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
      lock_d   = 1'b0;
    end else if (walk_valid_o) begin
      lock_d     = 1'b1;
      lock_idx_d = grant_idx;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      if (orphan) err_q <= 1'b1;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (walk_hs) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (rsp_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_q + CntW'(walk_hs) - CntW'(rsp_pop);
      end
    end
  end

  // ID storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (walk_hs) fifo_q[wr_ptr_q] <= grant_idx;
  end

`ifdef MPTW_ARB_PERF_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_perf
    logic [15:0] cnt_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt_q <= '0;
      end else if (walk_hs && (32'(grant_idx) == i) && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
    assign grant_cnt_o[i*16 +: 16] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_mptw_req_arbiter.sv
// Self-checking bench: directed scenarios followed by random traffic, all outputs compared
// each cycle against a queue-based reference model.
module tb_mptw_req_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int RW = 32;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    rv;
  logic [DW-1:0]   rdat [N];
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            walk_valid, wrdy;
  logic [DW-1:0]   walk_data;
  logic            rspv, rsp_ready;
  logic [RW-1:0]   rspd, cli_data;
  logic [N-1:0]    cli_valid, crdy;
  logic            flush, busy, err;
`ifdef MPTW_ARB_PERF_EN
  logic [N*16-1:0] grant_cnt;
`endif

  always_comb begin
    req_data = '0;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = rdat[i];
  end

  mptw_req_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .RSP_WIDTH(RW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(rv), .req_ready_o(req_ready), .req_data_i(req_data),
    .walk_valid_o(walk_valid), .walk_ready_i(wrdy), .walk_data_o(walk_data),
    .rsp_valid_i(rspv), .rsp_ready_o(rsp_ready), .rsp_data_i(rspd),
    .cli_rsp_valid_o(cli_valid), .cli_rsp_ready_i(crdy), .cli_rsp_data_o(cli_data),
    .flush_i(flush), .busy_o(busy), .err_o(err)
`ifdef MPTW_ARB_PERF_EN
    , .grant_cnt_o(grant_cnt)
`endif
  );

  // Reference model state
  int rr, held, last_acc;
  int outq[$];
  bit merr;
  int gcnt [N];
  int n_chk, n_pass;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    outq.delete();
    rr = 0; held = -1; merr = 0; last_acc = -1;
    for (int i = 0; i < N; i++) gcnt[i] = 0;
  endtask

  task automatic idle_inputs();
    rv = '0; wrdy = 0; rspv = 0; crdy = '0; flush = 0; rspd = '0;
  endtask

  // Compare every output against the model, then advance model and clock.
  task automatic cycle();
    int g, h;
    logic [N-1:0] e_rdy, e_cv;
    logic e_rr;
    logic [N*16-1:0] e_gc;
    #1;
    g = -1;
    if (!flush && outq.size() < MO) begin
      if (held >= 0) g = held;
      else for (int k = 0; k < N; k++) if (g < 0 && rv[(rr+k)%N]) g = (rr + k) % N;
    end
    chk("walk_valid", walk_valid, g >= 0);
    e_rdy = '0;
    if (g >= 0 && wrdy) e_rdy[g] = 1'b1;
    chk("req_ready", req_ready, e_rdy);
    if (g >= 0) chk("walk_data", walk_data, rdat[g]);
    e_cv = '0; e_rr = 1'b1;
    if (!flush && outq.size() > 0) begin
      h = outq[0];
      if (rspv) e_cv[h] = 1'b1;
      e_rr = crdy[h];
    end
    chk("cli_rsp_valid", cli_valid, e_cv);
    chk("rsp_ready", rsp_ready, e_rr);
    if (|e_cv) chk("cli_rsp_data", cli_data, rspd);
    chk("busy", busy, outq.size() != 0);
    chk("err", err, merr);
    for (int i = 0; i < N; i++) e_gc[i*16 +: 16] = (gcnt[i] > 65535) ? 16'hFFFF : 16'(gcnt[i]);
`ifdef MPTW_ARB_PERF_EN
    chk("grant_cnt", grant_cnt, e_gc);
`endif
    last_acc = (g >= 0 && wrdy) ? g : -1;
    if (flush) begin
      outq.delete(); rr = 0; held = -1;
    end else begin
      if (outq.size() > 0) begin
        if (rspv && crdy[outq[0]]) void'(outq.pop_front());
      end else if (rspv) begin
        merr = 1;
      end
      if (g >= 0) begin
        if (wrdy) begin
          outq.push_back(g); rr = (g + 1) % N; held = -1; gcnt[g]++;
        end else begin
          held = g;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    model_reset();
    for (int i = 0; i < N; i++) rdat[i] = 32'hA000_0000 | i;
    // Reset with busy-looking inputs: every output must be quiet.
    rv = '1; wrdy = 1; rspv = 1; crdy = '1; flush = 0; rspd = '0;
    #12;
    chk("rst_walk_valid", walk_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_cli_valid", cli_valid, 0);
    chk("rst_rsp_ready", rsp_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    idle_inputs();
    rst = 0;
    @(posedge clk); #1;

    // Requesters 0 and 2 alternate; responses come back in the same order.
    rv = 4'b0101; wrdy = 1; crdy = '1;
    for (int j = 0; j < 4; j++) begin
      #1; chk("rr_grant", req_ready, (j % 2) ? 4'b0100 : 4'b0001);
      cycle();
    end
    rv = '0; wrdy = 0; rspv = 1;
    for (int j = 0; j < 4; j++) begin
      rspd = 32'h5000 + j;
      #1; chk("rr_rsp_route", cli_valid, (j % 2) ? 4'b0100 : 4'b0001);
      cycle();
    end
    rspv = 0;

    // Stalled grant to requester 1 survives requester 0 becoming eligible first.
    flush = 1; cycle(); flush = 0;
    rv = 4'b0010; wrdy = 1; cycle();
    wrdy = 0;
    for (int j = 0; j < 3; j++) begin
      rv = (j == 0) ? 4'b0010 : 4'b0011;
      rdat[0] = 32'hB000_0000 + j;
      #1; chk("lock_data", walk_data, 32'hA000_0001);
      chk("lock_ready", req_ready, 4'b0000);
      cycle();
    end
    wrdy = 1;
    #1; chk("lock_accept", req_ready, 4'b0010);
    cycle();
    rv = 4'b0001;
    #1; chk("lock_next", req_ready, 4'b0001);
    cycle();
    rv = '0; rspv = 1;
    for (int j = 0; j < 3; j++) cycle();
    rspv = 0;

    // Fill to MAX_OUTSTANDING; a pop in the blocked cycle does not unblock it.
    rv = '1; wrdy = 1;
    for (int j = 0; j < MO; j++) cycle();
    rspv = 1;
    #1; chk("full_block", walk_valid, 0);
    chk("full_busy", busy, 1);
    cycle();
    rspv = 0;
    #1; chk("full_resume", walk_valid, 1);
    cycle();

    // Flush with 3 outstanding and a stalled grant, then an orphan response.
    rv = '0; rspv = 1; cycle(); rspv = 0;
    rv = '1; wrdy = 0; cycle();
    flush = 1;
    #1; chk("flush_walk_valid", walk_valid, 0);
    chk("flush_req_ready", req_ready, 0);
    chk("flush_rsp_ready", rsp_ready, 1);
    cycle();
    flush = 0; rv = '0;
    #1; chk("flush_busy", busy, 0);
    chk("flush_err", err, 0);
    rspv = 1;
    #1; chk("orphan_ready", rsp_ready, 1);
    chk("orphan_cli", cli_valid, 0);
    cycle();
    rspv = 0;
    #1; chk("orphan_err", err, 1);
    rv = '1; wrdy = 1;
    #1; chk("flush_rr0", walk_data, rdat[0]);
    cycle();
    rv = '0; wrdy = 0; rspv = 1; crdy = '1; cycle(); rspv = 0;

    // Reset mid-operation.
    rv = '1; wrdy = 1; cycle(); cycle();
    wrdy = 0; rspv = 1;
    #1; rst = 1; #1;
    chk("midrst_walk_valid", walk_valid, 0);
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_rsp_ready", rsp_ready, 0);
    chk("midrst_cli_valid", cli_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_err", err, 0);
    @(posedge clk); #1;
    idle_inputs(); rst = 0; model_reset();
    cycle();

`ifdef MPTW_ARB_PERF_EN
    rv = 4'b1000; wrdy = 1; crdy = '1;
    for (int j = 0; j < 5; j++) begin
      rspv = (j != 0);
      cycle();
    end
    idle_inputs();
    chk("perf_cnt", grant_cnt, {16'd5, 16'd0, 16'd0, 16'd0});
    rv = 4'b0000; rspv = 1; crdy = '1; cycle(); rspv = 0;
`endif

    // Random traffic; requesters hold valid and data until accepted.
    rv = '0; last_acc = -1;
    for (int it = 0; it < 3000; it++) begin
      for (int i = 0; i < N; i++) begin
        if (last_acc == i) rv[i] = 1'b0;
        if (!rv[i]) begin
          rv[i]   = ($urandom % 3 == 0);
          rdat[i] = $urandom;
        end
      end
      wrdy  = ($urandom % 4 != 0);
      crdy  = N'($urandom);
      rspv  = (outq.size() > 0) ? 1'($urandom % 2) : ($urandom % 200 == 0);
      rspd  = $urandom;
      flush = ($urandom % 50 == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mptw_req_arbiter.md
MPTW_REQ_ARBITER -- requirements
Module: mptw_req_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of walk requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of the walk transaction bus.
REQ-003 SHALL have parameter RSP_WIDTH, default 32, width of the walk response bus.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, in-flight walk limit (power of two, 2..16).
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk_i  in  1  clock; rst_i  in  1  reset.
REQ-006 SHALL have req_valid_i  in  NUM_REQ  per-requester transaction valid.
REQ-007 SHALL have req_ready_o  out  NUM_REQ  per-requester accept.
REQ-008 SHALL have req_data_i  in  NUM_REQ*DATA_WIDTH  packed transactions, requester i at slice i.
REQ-009 SHALL have walk_valid_o / walk_ready_i / walk_data_o  out/in/out  1/1/DATA_WIDTH  to walker fetch stage.
REQ-010 SHALL have rsp_valid_i / rsp_ready_o / rsp_data_i  in/out/in  1/1/RSP_WIDTH  from walker last stage.
REQ-011 SHALL have cli_rsp_valid_o  out  NUM_REQ, cli_rsp_ready_i  in  NUM_REQ, cli_rsp_data_o  out  RSP_WIDTH  routed responses.
REQ-012 SHALL have flush_i  in  1, busy_o  out  1 (outstanding != 0), err_o  out  1 sticky orphan-response flag.

Function
REQ-013 SHALL arbitrate round-robin: the first requester with req_valid_i set, searching upward (with wrap) from rr_ptr, wins.
REQ-014 SHALL forward winner data combinationally to walk_data_o with walk_valid_o=1 (zero-cycle latency).
REQ-015 SHALL lock the grant while walk_valid_o && !walk_ready_i; the winner and data stay stable until the handshake.
REQ-016 SHALL assert req_ready_o[g] = walk_ready_i only for granted g; all others 0.
REQ-017 SHALL, on walk handshake, push index g into an in-order ID FIFO (depth MAX_OUTSTANDING) and set rr_ptr = (g+1) mod NUM_REQ.
REQ-018 SHALL issue nothing (walk_valid_o=0, all req_ready_o=0) when the FIFO is full; a same-cycle pop does not unblock issue.
REQ-019 SHALL route a response to the FIFO head: cli_rsp_valid_o[head]=rsp_valid_i, rsp_ready_o=cli_rsp_ready_i[head], and pop on handshake.
REQ-020 SHALL support a simultaneous push and pop in one cycle (not full), leaving the count unchanged.
REQ-021 SHALL, when rsp_valid_i=1 with the FIFO empty, drive rsp_ready_o=1, drop the beat, and set err_o (cleared only by reset).
REQ-022 SHALL, on flush_i=1, clear the FIFO and set rr_ptr=0 next cycle; during flush, walk_valid_o=0, req_ready_o=0, cli_rsp_valid_o=0, rsp_ready_o=1; no err_o is set.
REQ-023 SHALL drop a locked but unaccepted grant on flush; arbitration restarts from rr_ptr=0.

Reset
REQ-024 SHALL reset asynchronously on rst_i=1: FIFO empty, rr_ptr=0, lock clear, err_o=0, busy_o=0, walk_valid_o=0, req_ready_o=0, cli_rsp_valid_o=0, rsp_ready_o=0.
REQ-025 SHALL discard all in-flight state when reset is asserted mid-operation; outputs follow REQ-024 in the same cycle.

Configuration
REQ-026 SHALL, with MPTW_ARB_PERF_EN defined, add grant_cnt_o  out  NUM_REQ*16: per-requester saturating (at 16'hFFFF) counters that increment on each walk handshake and reset to 0 on rst_i; flush_i does not clear them.
REQ-027 SHALL, without MPTW_ARB_PERF_EN, omit the port and all counter logic.

Verification
REQ-028 SHALL test requesters 0,2 valid, walk_ready_i=1 continuously -> grants 0,2,0,2; cli responses return to 0,2,0,2.
REQ-029 SHALL test requester 1 valid with walk_ready_i low for 3 cycles while requester 0 asserts -> walk_data_o holds req 1 data; req 1 accepted on cycle 4, then req 0.
REQ-030 SHALL test 4 issues with no responses (MAX_OUTSTANDING=4) -> 5th blocked, busy_o=1; one response -> issue resumes next cycle.
REQ-031 SHALL test a response with the FIFO empty -> rsp_ready_o=1, no cli_rsp_valid_o, err_o=1 thereafter.
REQ-032 SHALL test flush_i with 3 outstanding and a stalled grant -> next cycle busy_o=0, rr_ptr=0; a later response sets err_o.
REQ-033 SHALL test, with MPTW_ARB_PERF_EN, 5 grants to requester 3 -> grant_cnt_o slice 3 = 5 and other slices 0.
